lc_power_sequencer: RTL and testbench

//  Always-on FSM that generates the layer-controller power-gating controls consumed by the LC

---
 rtl/lc_power_sequencer.sv | 151 +++++++++++++++
 tb/tb_lc_power_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lc_power_sequencer.sv
// Always-on power-gating sequencer for the layer controller: ramps power, clock, reset and
// isolation up in that order on a wake, and back down in reverse order on a sleep.
module lc_power_sequencer #(
  parameter int CNT_WIDTH = 8,
  parameter int PWR_DLY   = 4,
  parameter int CLK_DLY   = 2,
  parameter int RST_DLY   = 2,
  parameter int ISO_DLY   = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WAKE_REQ,
  input  logic       SLEEP_REQ,
  output logic       LC_POWER_ON,
  output logic       LC_RELEASE_CLK,
  output logic       LC_RELEASE_RST,
  output logic       LC_RELEASE_ISO,
  output logic       LC_ACTIVE,
  output logic       BUSY,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_PWR_UP = 3'd1,
    S_CLK_UP = 3'd2,
    S_RST_UP = 3'd3,
    S_ACTIVE = 3'd4,
    S_ISO_DN = 3'd5,
    S_RST_DN = 3'd6,
    S_CLK_DN = 3'd7
  } state_t;

  typedef struct packed {
    logic power_on;
    logic release_clk;
    logic release_rst;
    logic release_iso;
    logic active;
    logic busy;
  } ctl_t;

  localparam logic [CNT_WIDTH-1:0] PWR_LOAD = CNT_WIDTH'(PWR_DLY - 1);
  localparam logic [CNT_WIDTH-1:0] CLK_LOAD = CNT_WIDTH'(CLK_DLY - 1);
  localparam logic [CNT_WIDTH-1:0] RST_LOAD = CNT_WIDTH'(RST_DLY - 1);
  localparam logic [CNT_WIDTH-1:0] ISO_LOAD = CNT_WIDTH'(ISO_DLY - 1);

  // Control word held while in a given state; registered together with the state itself.
  function automatic ctl_t ctl_of(state_t s);
    case (s)
      S_OFF:    ctl_of = ctl_t'(6'b111100);
      S_PWR_UP: ctl_of = ctl_t'(6'b011101);
      S_CLK_UP: ctl_of = ctl_t'(6'b001101);
      S_RST_UP: ctl_of = ctl_t'(6'b000101);
      S_ACTIVE: ctl_of = ctl_t'(6'b000010);
      S_ISO_DN: ctl_of = ctl_t'(6'b000101);
      S_RST_DN: ctl_of = ctl_t'(6'b001101);
      S_CLK_DN: ctl_of = ctl_t'(6'b011101);
      default:  ctl_of = ctl_t'(6'b111100);
    endcase
  endfunction

  state_t               state;
  ctl_t                 ctl;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 wake_pend;
  logic                 sleep_pend;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_OFF;
      ctl        <= ctl_of(S_OFF);
      cnt        <= '0;
      wake_pend  <= 1'b0;
      sleep_pend <= 1'b0;
    end else begin
      // NOTE: the saturating decrement is a default; a reload later in this block
      // overrides it because the last non-blocking assignment to cnt wins.
      if (cnt != '0) cnt <= cnt - 1'b1;

      unique case (state)
        S_OFF: begin
          if (WAKE_REQ || wake_pend) begin
            state     <= S_PWR_UP;
            ctl       <= ctl_of(S_PWR_UP);
            cnt       <= PWR_LOAD;
            wake_pend <= 1'b0;
          end
        end
        S_PWR_UP: begin
          if (SLEEP_REQ) sleep_pend <= 1'b1;
          if (cnt == '0) begin
            state <= S_CLK_UP;
            ctl   <= ctl_of(S_CLK_UP);
            cnt   <= CLK_LOAD;
          end
        end
        S_CLK_UP: begin
          if (SLEEP_REQ) sleep_pend <= 1'b1;
          if (cnt == '0) begin
            state <= S_RST_UP;
            ctl   <= ctl_of(S_RST_UP);
            cnt   <= RST_LOAD;
          end
        end
        S_RST_UP: begin
          if (SLEEP_REQ) sleep_pend <= 1'b1;
          if (cnt == '0) begin
            state <= S_ACTIVE;
            ctl   <= ctl_of(S_ACTIVE);
          end
        end
        S_ACTIVE: begin
          // A sleep that arrived during the ramp-up is honoured one cycle after arrival here.
          if (SLEEP_REQ || sleep_pend) begin
            state      <= S_ISO_DN;
            ctl        <= ctl_of(S_ISO_DN);
            cnt        <= ISO_LOAD;
            sleep_pend <= 1'b0;
          end
        end
        S_ISO_DN: begin
          if (WAKE_REQ) wake_pend <= 1'b1;
          if (cnt == '0) begin
            state <= S_RST_DN;
            ctl   <= ctl_of(S_RST_DN);
          end
        end
        S_RST_DN: begin
          if (WAKE_REQ) wake_pend <= 1'b1;
          state <= S_CLK_DN;
          ctl   <= ctl_of(S_CLK_DN);
        end
        S_CLK_DN: begin
          if (WAKE_REQ) wake_pend <= 1'b1;
          state <= S_OFF;
          ctl   <= ctl_of(S_OFF);
        end
      endcase
    end
  end

  assign LC_POWER_ON    = ctl.power_on;
  assign LC_RELEASE_CLK = ctl.release_clk;
  assign LC_RELEASE_RST = ctl.release_rst;
  assign LC_RELEASE_ISO = ctl.release_iso;
  assign LC_ACTIVE      = ctl.active;
  assign BUSY           = ctl.busy;
  assign STATE          = state;

endmodule

// File: tb/tb_lc_power_sequencer.sv
// Self-checking bench for lc_power_sequencer: directed per-cycle vector table through a
// scoreboard queue, then a random request phase checking ordering and request service.
module tb_lc_power_sequencer;

  localparam logic [2:0] OFF  = 3'd0;
  localparam logic [2:0] PWR  = 3'd1;
  localparam logic [2:0] CLKU = 3'd2;
  localparam logic [2:0] RSTU = 3'd3;
  localparam logic [2:0] ACT  = 3'd4;
  localparam logic [2:0] ISO  = 3'd5;
  localparam logic [2:0] RSTD = 3'd6;
  localparam logic [2:0] CLKD = 3'd7;

  localparam int SERVE_BOUND = 40;

  logic       CLK;
  logic       RESET;
  logic       WAKE_REQ;
  logic       SLEEP_REQ;
  logic       LC_POWER_ON;
  logic       LC_RELEASE_CLK;
  logic       LC_RELEASE_RST;
  logic       LC_RELEASE_ISO;
  logic       LC_ACTIVE;
  logic       BUSY;
  logic [2:0] STATE;

  lc_power_sequencer dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .WAKE_REQ       (WAKE_REQ),
    .SLEEP_REQ      (SLEEP_REQ),
    .LC_POWER_ON    (LC_POWER_ON),
    .LC_RELEASE_CLK (LC_RELEASE_CLK),
    .LC_RELEASE_RST (LC_RELEASE_RST),
    .LC_RELEASE_ISO (LC_RELEASE_ISO),
    .LC_ACTIVE      (LC_ACTIVE),
    .BUSY           (BUSY),
    .STATE          (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       wake;
    logic       sleep;
    logic [2:0] st;
  } vec_t;

  typedef struct {
    int         idx;
    logic [2:0] st;
    logic [5:0] outs;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  logic [5:0] exp_outs [8];
  int         n_pass  = 0;
  int         n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
  endtask

  function automatic void add(input int n, input logic r, input logic w, input logic s,
                              input logic [2:0] st);
    for (int i = 0; i < n; i++) vecs.push_back('{rst: r, wake: w, sleep: s, st: st});
  endfunction

  function automatic logic [5:0] dut_outs();
    return {LC_POWER_ON, LC_RELEASE_CLK, LC_RELEASE_RST, LC_RELEASE_ISO, LC_ACTIVE, BUSY};
  endfunction

  initial begin
    exp_t       e;
    logic [2:0] pre_st;
    logic       w;
    logic       s;
    logic       inv_ok;
    int         wake_dl;
    int         sleep_dl;

    // {POWER_ON, RELEASE_CLK, RELEASE_RST, RELEASE_ISO, LC_ACTIVE, BUSY} for each state
    exp_outs[OFF]  = 6'b111100;
    exp_outs[PWR]  = 6'b011101;
    exp_outs[CLKU] = 6'b001101;
    exp_outs[RSTU] = 6'b000101;
    exp_outs[ACT]  = 6'b000010;
    exp_outs[ISO]  = 6'b000101;
    exp_outs[RSTD] = 6'b001101;
    exp_outs[CLKD] = 6'b011101;

    // Reset, idle, lone sleep in OFF, full wake, lone wake in ACTIVE, sleep+wake in ACTIVE.
    add(1, 1, 0, 0, OFF);  add(2, 0, 0, 0, OFF);  add(1, 0, 0, 1, OFF);
    add(1, 0, 1, 0, PWR);  add(3, 0, 0, 0, PWR);  add(2, 0, 0, 0, CLKU);
    add(2, 0, 0, 0, RSTU); add(1, 0, 0, 0, ACT);
    add(1, 0, 1, 0, ACT);  add(2, 0, 0, 0, ACT);
    add(1, 0, 1, 1, ISO);  add(1, 0, 0, 0, RSTD); add(1, 0, 0, 0, CLKD); add(2, 0, 0, 0, OFF);
    // Sleep two edges into PWR_UP: one-cycle ACTIVE, then power-down.
    add(1, 0, 1, 0, PWR);  add(1, 0, 0, 0, PWR);  add(1, 0, 0, 1, PWR);  add(1, 0, 0, 0, PWR);
    add(2, 0, 0, 0, CLKU); add(2, 0, 0, 0, RSTU); add(1, 0, 0, 0, ACT);
    add(1, 0, 0, 0, ISO);  add(1, 0, 0, 0, RSTD); add(1, 0, 0, 0, CLKD); add(2, 0, 0, 0, OFF);
    // Wake during CLK_DN: one OFF cycle, then a full ramp; sleeps during power-down ignored.
    add(1, 0, 1, 0, PWR);  add(3, 0, 0, 0, PWR);  add(2, 0, 0, 0, CLKU);
    add(2, 0, 0, 0, RSTU); add(1, 0, 0, 0, ACT);
    add(1, 0, 0, 1, ISO);  add(1, 0, 0, 0, RSTD); add(1, 0, 0, 0, CLKD); add(1, 0, 1, 0, OFF);
    add(1, 0, 0, 0, PWR);  add(3, 0, 0, 0, PWR);  add(2, 0, 0, 0, CLKU);
    add(2, 0, 0, 0, RSTU); add(1, 0, 0, 0, ACT);
    add(1, 0, 0, 1, ISO);  add(1, 0, 0, 1, RSTD); add(1, 0, 0, 1, CLKD); add(3, 0, 0, 0, OFF);
    // Reset in CLK_UP with sleep pending, then reset in RST_DN with wake pending.
    add(1, 0, 1, 0, PWR);  add(1, 0, 0, 1, PWR);  add(2, 0, 0, 0, PWR);  add(1, 0, 0, 0, CLKU);
    add(1, 1, 0, 0, OFF);  add(3, 0, 0, 0, OFF);
    add(1, 0, 1, 0, PWR);  add(3, 0, 0, 0, PWR);  add(2, 0, 0, 0, CLKU);
    add(2, 0, 0, 0, RSTU); add(1, 0, 0, 0, ACT);  add(2, 0, 0, 0, ACT);
    add(1, 0, 0, 1, ISO);  add(1, 0, 1, 0, RSTD); add(1, 1, 0, 0, OFF);  add(2, 0, 0, 0, OFF);

    RESET = 1'b1; WAKE_REQ = 1'b0; SLEEP_REQ = 1'b0;
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      sb.push_back('{idx: i, st: vecs[i].st, outs: exp_outs[vecs[i].st]});
      RESET     = vecs[i].rst;
      WAKE_REQ  = vecs[i].wake;
      SLEEP_REQ = vecs[i].sleep;
      @(posedge CLK); #1;
      e = sb.pop_front();
      check($sformatf("vec%0d_state", e.idx), 32'(STATE), 32'(e.st));
      check($sformatf("vec%0d_outs", e.idx), 32'(dut_outs()), 32'(e.outs));
    end

    // Random phase: a wake seen outside ACTIVE must lead to ACTIVE, a sleep seen outside
    // OFF must lead to OFF, each within a bounded number of cycles.
    RESET = 1'b0; wake_dl = 0; sleep_dl = 0;
    for (int c = 0; c < 10000; c++) begin
      w = ($urandom_range(0, 9) < 2);
      s = ($urandom_range(0, 9) < 2);
      pre_st    = STATE;
      WAKE_REQ  = w;
      SLEEP_REQ = s;
      @(posedge CLK); #1;

      inv_ok = 1'b1;
      if (LC_POWER_ON && !(LC_RELEASE_CLK && LC_RELEASE_RST && LC_RELEASE_ISO)) inv_ok = 1'b0;
      if (!LC_RELEASE_ISO && (LC_RELEASE_RST || LC_RELEASE_CLK)) inv_ok = 1'b0;
      check("rand_ordering", 32'(inv_ok), 32'd1);
      check("rand_outs", 32'(dut_outs()), 32'(exp_outs[STATE]));

      if (w && pre_st != ACT && wake_dl == 0) wake_dl = SERVE_BOUND;
      if (s && pre_st != OFF && sleep_dl == 0) sleep_dl = SERVE_BOUND;
      if (wake_dl > 0) begin
        wake_dl--;
        if (STATE == ACT || wake_dl == 0) begin
          check("rand_wake_served", 32'(STATE == ACT), 32'd1);
          wake_dl = 0;
        end
      end
      if (sleep_dl > 0) begin
        sleep_dl--;
        if (STATE == OFF || sleep_dl == 0) begin
          check("rand_sleep_served", 32'(STATE == OFF), 32'd1);
          sleep_dl = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
